// File: rtl/sb_hfosc.sv
`default_nettype none
// ============================================================================
// Module   : sb_hfosc
// Brief    : iCE40UP HFOSC model; CLKHF derived from clk with power-up delay,
//            enable gating and static power-of-two divider.
//            Optional CLKHF_READY output when SB_HFOSC_READY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module sb_hfosc #(
    parameter logic [1:0]  CLKHF_DIV = 2'b00,
    parameter int unsigned PU_DELAY  = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic CLKHFPU,
    input  logic CLKHFEN,
    output logic CLKHF
`ifdef SB_HFOSC_READY_EN
    ,
    output logic CLKHF_READY
`endif
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    localparam logic [2:0]  c_div_tc  = 3'((4'd1 << CLKHF_DIV) - 4'd1);
    localparam logic [15:0] c_pu_last = 16'(PU_DELAY - 1);

    state_t      state_q, state_d;
    logic [15:0] pu_cnt_q, pu_cnt_d;
    logic [2:0]  div_cnt_q, div_cnt_d;
    logic        clkhf_q, clkhf_d;
    logic        run_q, run_d;
    logic        w_div_tc;

    assign w_div_tc = (div_cnt_q == c_div_tc);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_OFF;
            pu_cnt_q  <= 16'd0;
            div_cnt_q <= 3'd0;
            clkhf_q   <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pu_cnt_q  <= pu_cnt_d;
            div_cnt_q <= div_cnt_d;
            clkhf_q   <= clkhf_d;
            run_q     <= run_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pu_cnt_d  = pu_cnt_q;
        div_cnt_d = div_cnt_q;
        clkhf_d   = clkhf_q;
        run_d     = run_q;
        // Power-down overrides everything, including an in-progress high phase.
        if (!CLKHFPU) begin
            state_d   = ST_OFF;
            pu_cnt_d  = 16'd0;
            div_cnt_d = 3'd0;
            clkhf_d   = 1'b0;
            run_d     = 1'b0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d   = ST_WAIT;
                    pu_cnt_d  = 16'd0;
                    div_cnt_d = 3'd0;
                    clkhf_d   = 1'b0;
                    run_d     = 1'b0;
                end
                ST_WAIT: begin
                    pu_cnt_d = pu_cnt_q + 16'd1;
                    if (pu_cnt_q == c_pu_last) begin
                        state_d = ST_READY;
                    end
                end
                ST_READY: begin
                    if (!run_q) begin
                        div_cnt_d = 3'd0;
                        clkhf_d   = CLKHFEN;
                        run_d     = CLKHFEN;
                    end else if (clkhf_q) begin
                        // High phase always runs to full length; enable only
                        // decides whether a low phase follows.
                        if (w_div_tc) begin
                            clkhf_d   = 1'b0;
                            div_cnt_d = 3'd0;
                            run_d     = CLKHFEN;
                        end else begin
                            div_cnt_d = div_cnt_q + 3'd1;
                        end
                    end else if (!CLKHFEN) begin
                        run_d     = 1'b0;
                        div_cnt_d = 3'd0;
                        clkhf_d   = 1'b0;
                    end else if (w_div_tc) begin
                        clkhf_d   = 1'b1;
                        div_cnt_d = 3'd0;
                    end else begin
                        div_cnt_d = div_cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end
    end

    assign CLKHF = clkhf_q;

`ifdef SB_HFOSC_READY_EN
    logic ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= (state_d == ST_READY);
        end
    end

    assign CLKHF_READY = ready_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sb_hfosc.sv
`default_nettype none
// ============================================================================
// Module   : tb_sb_hfosc
// Brief    : Directed bench for sb_hfosc with three divider/delay configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sb_hfosc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pu0, en0, pu2, en2, pu3, en3;
    logic clkhf0, clkhf2, clkhf3;
`ifdef SB_HFOSC_READY_EN
    logic rdy0, rdy2, rdy3;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    sb_hfosc #(.CLKHF_DIV(2'b00), .PU_DELAY(16)) u_div2 (
        .clk(clk), .rst(rst), .CLKHFPU(pu0), .CLKHFEN(en0), .CLKHF(clkhf0)
`ifdef SB_HFOSC_READY_EN
        , .CLKHF_READY(rdy0)
`endif
    );

    sb_hfosc #(.CLKHF_DIV(2'b10), .PU_DELAY(16)) u_div8 (
        .clk(clk), .rst(rst), .CLKHFPU(pu2), .CLKHFEN(en2), .CLKHF(clkhf2)
`ifdef SB_HFOSC_READY_EN
        , .CLKHF_READY(rdy2)
`endif
    );

    sb_hfosc #(.CLKHF_DIV(2'b11), .PU_DELAY(3)) u_div16 (
        .clk(clk), .rst(rst), .CLKHFPU(pu3), .CLKHFEN(en3), .CLKHF(clkhf3)
`ifdef SB_HFOSC_READY_EN
        , .CLKHF_READY(rdy3)
`endif
    );

    task automatic check(input string tag, input int e, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0h want %0h", tag, e, got, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge and are sampled on the next.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   rises;
        logic prev2;
        logic exp0, exp2, exp3;

        pu0 = 1'b1; en0 = 1'b1;
        pu2 = 1'b1; en2 = 1'b1;
        pu3 = 1'b1; en3 = 1'b1;
        rst = 1'b1;
        for (int r = 0; r < 3; r++) begin
            step();
            check("rst_div2", r, 32'(clkhf0), 32'd0);
            check("rst_div8", r, 32'(clkhf2), 32'd0);
            check("rst_div16", r, 32'(clkhf3), 32'd0);
`ifdef SB_HFOSC_READY_EN
            check("rst_ready", r, 32'(rdy0), 32'd0);
`endif
        end
        rst = 1'b0;

        rises = 0;
        prev2 = 1'b0;
        // Edge 0 is the first edge after reset release, with CLKHFPU/CLKHFEN high.
        for (int e = 0; e <= 120; e++) begin
            step();

            // div/2, delay 16: rise at 17, power-down sampled at 23, re-power at 25.
            if (e >= 17 && e <= 22)      exp0 = ((e - 17) % 2) == 0;
            else if (e >= 42)            exp0 = ((e - 42) % 2) == 0;
            else                         exp0 = 1'b0;
            check("div2_clkhf", e, 32'(clkhf0), 32'(exp0));

            // div/8, delay 16: period 8 from edge 17, powered down at edge 115.
            exp2 = (e >= 17 && e <= 114) ? (((e - 17) % 8) < 4) : 1'b0;
            check("div8_clkhf", e, 32'(clkhf2), 32'(exp2));
            if (e >= 17 && e <= 116 && clkhf2 && !prev2) rises++;
            prev2 = clkhf2;

            // div/16, delay 3: enable drop/re-enable, tail re-assert, power-down race.
            exp3 = (e >= 4  && e <= 11) || (e >= 16 && e <= 23) ||
                   (e >= 32 && e <= 39) || (e >= 48 && e <= 55);
            check("div16_clkhf", e, 32'(clkhf3), 32'(exp3));

`ifdef SB_HFOSC_READY_EN
            check("div2_ready", e, 32'(rdy0),
                  32'((e >= 16 && e <= 22) || (e >= 41)));
            check("div16_ready", e, 32'(rdy3), 32'(e >= 3 && e <= 57));
`endif

            case (e)
                4:  en3 = 1'b0;
                15: en3 = 1'b1;
                22: pu0 = 1'b0;
                24: pu0 = 1'b1;
                33: en3 = 1'b0;
                35: en3 = 1'b1;
                56: en3 = 1'b0;
                57: begin pu3 = 1'b0; en3 = 1'b1; end
                114: pu2 = 1'b0;
                default: ;
            endcase
        end

        check("div8_rises_100clk", 116, 32'(rises), 32'd13);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
